// File: rtl/subtraction_module_8bit_seq.sv
// Bit-serial signed subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Signed overflow forces Diff to zero; Start/Busy/Done handshake with one-cycle Done.
module subtraction_module_8bit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bw_q, bw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic               bit_a_s, bit_b_s, bit_d_s, bw_nxt_s, ovf_s;

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bw_d     = bw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    bit_a_s  = a_q[cnt_q];
    bit_b_s  = b_q[cnt_q];
    bit_d_s  = bit_a_s ^ bit_b_s ^ bw_q;
    bw_nxt_s = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & bw_q);
    // borrow into the MSB versus borrow out of it
    ovf_s    = bw_q ^ bw_nxt_s;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SHIFT;
          a_d     = A;
          b_d     = B;
          bw_d    = Bin;
          res_d   = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d[cnt_q] = bit_d_s;
        bw_d         = bw_nxt_s;
        cnt_d        = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          borrow_d = bw_nxt_s;
          ovf_d    = ovf_s;
          diff_d   = ovf_s ? {WIDTH{1'b0}} : res_d;
        end else begin
          state_d  = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      bw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Diff     = diff_q;
  assign Borrow   = borrow_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_subtraction_module_8bit_seq.sv
// Randomized self-checking bench for the bit-serial subtractor, with an
// arithmetic reference model and directed latency/reset/back-to-back cases.
module tb_subtraction_module_8bit_seq;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       Busy;
  logic       Done;
  logic [7:0] Diff;
  logic       Borrow;
  logic       Overflow;

  int checks;
  int failures;

  subtraction_module_8bit_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Borrow(Borrow), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: {overflow, borrow, diff} from plain integer arithmetic
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int sa, sb, sd, ud;
    logic ovf, brw;
    logic [7:0] d;
    sa = int'(a);
    sb = int'(b);
    if (a[7]) sa = sa - 256;
    if (b[7]) sb = sb - 256;
    sd  = sa - sb - int'(bin);
    ud  = int'(a) - int'(b) - int'(bin);
    ovf = (sd < -128) || (sd > 127);
    brw = (ud < 0);
    d   = ovf ? 8'h00 : 8'(ud);
    return {ovf, brw, d};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-level model: accept Start when idle, report result 8 edges later
  logic       m_busy, m_done, m_ovf, m_borrow, m_bin;
  logic [7:0] m_diff, m_a, m_b;
  int         m_left;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_diff <= 8'h00; m_borrow <= 1'b0; m_ovf <= 1'b0;
      m_left <= 0; m_a <= 8'h00; m_b <= 8'h00; m_bin <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_ovf, m_borrow, m_diff} <= ref_sub(m_a, m_b, m_bin);
        end
        m_left <= m_left - 1;
      end else if (Start) begin
        m_a <= A; m_b <= B; m_bin <= Bin;
        m_busy <= 1'b1;
        m_left <= 8;
      end
    end
  end

  // Every-cycle comparison of DUT against the model
  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("cyc_busy", int'(Busy), int'(m_busy));
      chk("cyc_done", int'(Done), int'(m_done));
      chk("cyc_diff", int'(Diff), int'(m_diff));
      chk("cyc_borrow", int'(Borrow), int'(m_borrow));
      chk("cyc_ovf", int'(Overflow), int'(m_ovf));
    end
  end

  // Issue one operation at a negedge; returns at the negedge where Done is seen
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo, input bit scramble);
    int n, busy_n;
    A = a; B = b; Bin = bin; Start = 1'b1;
    n = 0; busy_n = 0;
    while (n < 20) begin
      @(negedge Clk);
      n++;
      Start = 1'b0;
      if (scramble && n == 3) begin
        A = ~a; B = 8'($urandom); Bin = ~bin; Start = 1'b1;
      end
      if (Busy) busy_n++;
      if (Done) break;
    end
    chk("op_latency", n, 9);
    chk("op_busy_cycles", busy_n, 8);
    chk("op_diff", int'(Diff), int'(ed));
    chk("op_borrow", int'(Borrow), int'(eb));
    chk("op_ovf", int'(Overflow), int'(eo));
  endtask

  initial begin
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic       rbin;
    checks = 0; failures = 0;
    Rst_n = 1'b0; Start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;

    // Pin the reference model to hand-computed values
    chk("ref_05_03", int'(ref_sub(8'h05, 8'h03, 1'b0)), int'({1'b0, 1'b0, 8'h02}));
    chk("ref_03_05", int'(ref_sub(8'h03, 8'h05, 1'b0)), int'({1'b0, 1'b1, 8'hFE}));
    chk("ref_80_01", int'(ref_sub(8'h80, 8'h01, 1'b0)), int'({1'b1, 1'b0, 8'h00}));
    chk("ref_7f_ff", int'(ref_sub(8'h7F, 8'hFF, 1'b0)), int'({1'b1, 1'b1, 8'h00}));
    chk("ref_00_00_1", int'(ref_sub(8'h00, 8'h00, 1'b1)), int'({1'b0, 1'b1, 8'hFF}));
    chk("ref_10_01", int'(ref_sub(8'h10, 8'h01, 1'b0)), int'({1'b0, 1'b0, 8'h0F}));

    #23;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_diff", int'(Diff), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge Clk);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    // back-to-back: Start issued in the Done cycle
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    // Start and operand changes while busy must be ignored
    do_op(8'h40, 8'h15, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of SHIFT
    @(negedge Clk);
    A = 8'h22; B = 8'h11; Bin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(Busy), 0);
    chk("arst_done", int'(Done), 0);
    chk("arst_diff", int'(Diff), 0);
    chk("arst_borrow", int'(Borrow), 0);
    chk("arst_ovf", int'(Overflow), 0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk("arst_no_done", int'(Done), 0);
    end
    do_op(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

    // Randomized operations with random gaps and occasional mid-op disturbance
    for (int k = 0; k < 150; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (k % 10 == 0) begin ra = 8'h80; end
      if (k % 10 == 1) begin ra = 8'h7F; rb = 8'h80; end
      r = ref_sub(ra, rb, rbin);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      do_op(ra, rb, rbin, r[7:0], r[8], r[9], 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
